// File: rtl/tff_updown_counter_pkg.sv
// Shared constants for the T-flip-flop counter family (mode and direction encodings).
// Timer blocks built on tff_updown_counter import these as well.
package tff_updown_counter_pkg;

    localparam int unsigned TFF_MODE_WRAP = 0;
    localparam int unsigned TFF_MODE_SAT  = 1;

    localparam logic TFF_UP = 1'b1;
    localparam logic TFF_DN = 1'b0;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous active-high reset to rst_val and parallel load.
// Priority on each edge: reset, then load, then toggle.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= rst_val;
        end else if (ld) begin
            q_q <= d;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit synchronous up/down counter built from a bank of T flip-flops, with parallel
// load, wrap or saturate at the limits, terminal-count flag and a registered overflow pulse.
module tff_updown_counter
    import tff_updown_counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      SATURATE  = TFF_MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] t;
    logic             hit;
    logic             ovf_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign t_up[i] = 1'b1;
            assign t_dn[i] = 1'b1;
        end else begin : g_upper
            // Bit i toggles when every lower bit is at the rollover value for the direction.
            assign t_up[i] = &q[i-1:0];
            assign t_dn[i] = &(~q[i-1:0]);
        end

        tff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VAL[i]),
            .ld      (load),
            .d       (load_val[i]),
            .t       (t[i]),
            .q       (q[i])
        );
    end

    assign tc  = (up_dn == TFF_UP) ? (q == '1) : (q == '0);
    assign hit = en & ~load & tc;

    always_comb begin
        t = '0;
        // In saturate mode a limit hit freezes every cell instead of wrapping.
        if (en && !(hit && (SATURATE == TFF_MODE_SAT))) begin
            t = (up_dn == TFF_UP) ? t_up : t_dn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= hit;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: three instances (wrap, saturate, RESET_VAL=5) share stimulus
// and are each compared with an arithmetic reference model, plus fixed expected sequences.
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;

    logic [3:0] q_w, q_s, q_r;
    logic       tc_w, tc_s, tc_r;
    logic       ovf_w, ovf_s, ovf_r;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance: 0 = wrap, 1 = saturate, 2 = wrap with RESET_VAL 5.
    int m_q   [3];
    int m_ovf [3];
    int m_sat [3] = '{0, 1, 0};
    int m_rv  [3] = '{0, 0, 5};

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] lv;
        logic [3:0] q;
        logic       tc;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    tff_updown_counter #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    tff_updown_counter #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    tff_updown_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(0)) dut_r (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q_r), .tc(tc_r), .ovf(ovf_r)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [3:0] lv,
                                logic [3:0] q, logic tc, logic ovf);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = lv;
        v.q = q; v.tc = tc; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic u, input logic l,
                              input logic [3:0] lv);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_q[k] = m_rv[k];
                m_ovf[k] = 0;
            end else if (l) begin
                m_q[k] = int'(lv);
                m_ovf[k] = 0;
            end else if (e) begin
                int nxt;
                nxt = u ? m_q[k] + 1 : m_q[k] - 1;
                if (nxt < 0 || nxt > 15) begin
                    m_ovf[k] = 1;
                    if (m_sat[k] == 0) m_q[k] = (nxt + 16) % 16;
                end else begin
                    m_q[k] = nxt;
                    m_ovf[k] = 0;
                end
            end else begin
                m_ovf[k] = 0;
            end
        end
    endtask

    task automatic check_dut(input string name, input int k, input logic [3:0] q,
                             input logic tc, input logic ovf);
        int exp_tc;
        exp_tc = up_dn ? int'(m_q[k] == 15) : int'(m_q[k] == 0);
        check({name, ".q"}, int'(q), m_q[k]);
        check({name, ".tc"}, int'(tc), exp_tc);
        check({name, ".ovf"}, int'(ovf), m_ovf[k]);
    endtask

    // Drive one cycle's inputs, clock once, advance the model and compare every instance.
    task automatic apply(input logic r, input logic e, input logic u, input logic l,
                         input logic [3:0] lv);
        reset = r; en = e; up_dn = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
        model_step(r, e, u, l, lv);
        check_dut("model_wrap", 0, q_w, tc_w, ovf_w);
        check_dut("model_sat", 1, q_s, tc_s, ovf_s);
        check_dut("model_rv5", 2, q_r, tc_r, ovf_r);
    endtask

    initial begin
        // Wrap up-count through 15 -> 0.
        vecs.push_back(mk(1, 0, 1, 0, 4'h0, 4'h0, 0, 0));
        for (int k = 1; k <= 17; k++) begin
            vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'(k % 16), (k == 15), (k == 16)));
        end
        // Load 3, then count down through 0 -> 15.
        vecs.push_back(mk(0, 0, 0, 1, 4'h3, 4'h3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hF, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hE, 0, 0));
        // Load wins over en in the same cycle.
        vecs.push_back(mk(0, 1, 1, 1, 4'h9, 4'h9, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'hA, 0, 0));
        // Direction toggling around 6/7, then hold with en low.
        vecs.push_back(mk(0, 0, 1, 1, 4'h6, 4'h6, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'h7, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h6, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'h7, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h6, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h6, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv);
            check($sformatf("vec%0d.q", i), int'(q_w), int'(vecs[i].q));
            check($sformatf("vec%0d.tc", i), int'(tc_w), int'(vecs[i].tc));
            check($sformatf("vec%0d.ovf", i), int'(ovf_w), int'(vecs[i].ovf));
        end

        // Saturate: load E, count up and hold at F with ovf on every held cycle.
        apply(0, 0, 1, 1, 4'hE);
        check("sat_load.q", int'(q_s), 14);
        apply(0, 1, 1, 0, 4'h0);
        check("sat_f.q", int'(q_s), 15);
        check("sat_f.tc", int'(tc_s), 1);
        check("sat_f.ovf", int'(ovf_s), 0);
        for (int k = 0; k < 2; k++) begin
            apply(0, 1, 1, 0, 4'h0);
            check($sformatf("sat_hold%0d.q", k), int'(q_s), 15);
            check($sformatf("sat_hold%0d.tc", k), int'(tc_s), 1);
            check($sformatf("sat_hold%0d.ovf", k), int'(ovf_s), 1);
        end

        // Reset mid-count with en held high.
        apply(1, 1, 1, 0, 4'h0);
        check("rst5_init.q", int'(q_r), 5);
        for (int k = 0; k < 7; k++) apply(0, 1, 1, 0, 4'h0);
        check("cnt7.q", int'(q_w), 7);
        apply(1, 1, 1, 0, 4'h0);
        check("rst_mid.q", int'(q_w), 0);
        check("rst_mid.ovf", int'(ovf_w), 0);
        check("rst5_mid.q", int'(q_r), 5);
        apply(0, 1, 1, 0, 4'h0);
        check("rst_resume.q", int'(q_w), 1);

        // Randomised traffic checked against the model only.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
